// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - registered MIPS ID stage with ID/EX pipeline register
//
// Purpose:
//   Decodes one instruction per cycle into the ID/EX register, extends the
//   immediate to DWIDTH, stalls on load-use hazards by inserting a bubble,
//   supports flush, and reports and counts illegal opcodes.
//
// Ports:
//   d_clk, d_rst          clock, synchronous active-high reset
//   d_i_valid/d_o_ready   input handshake (accept when both high)
//   d_i_instr, d_i_pc     instruction word and its PC+4
//   d_i_flush             kill held output and the input this cycle
//   d_i_ex_ready          EX consumes the registered outputs this cycle
//   d_o_valid             registered outputs hold a real instruction
//   d_o_opcode..d_o_pc    decoded fields, ctrl = {j,jr,jal,branch,memtoreg,memwrite,reg_wr,alu_src}
//   d_o_illegal           one-cycle pulse after an illegal opcode is consumed
//   d_o_illegal_cnt       saturating count of illegal opcodes

module decode_stage_pipe #(
  parameter int IWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 5,
  parameter int JUMP_WIDTH = 26,
  parameter int CNT_WIDTH  = 8,
  parameter int HAZARD_EN  = 1
) (
  input  logic                  d_clk,
  input  logic                  d_rst,
  input  logic                  d_i_valid,
  output logic                  d_o_ready,
  input  logic [IWIDTH-1:0]     d_i_instr,
  input  logic [DWIDTH-1:0]     d_i_pc,
  input  logic                  d_i_flush,
  input  logic                  d_i_ex_ready,
  output logic                  d_o_valid,
  output logic [5:0]            d_o_opcode,
  output logic [5:0]            d_o_funct,
  output logic [AWIDTH-1:0]     d_o_addr_rs,
  output logic [AWIDTH-1:0]     d_o_addr_rt,
  output logic [AWIDTH-1:0]     d_o_addr_rd,
  output logic [DWIDTH-1:0]     d_o_imm,
  output logic [7:0]            d_o_ctrl,
  output logic [JUMP_WIDTH-1:0] d_o_jal_addr,
  output logic [DWIDTH-1:0]     d_o_pc,
  output logic                  d_o_illegal,
  output logic [CNT_WIDTH-1:0]  d_o_illegal_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [7:0] C_J        = 8'h80;
  localparam logic [7:0] C_JR       = 8'h40;
  localparam logic [7:0] C_JAL      = 8'h20;
  localparam logic [7:0] C_BRANCH   = 8'h10;
  localparam logic [7:0] C_MEMTOREG = 8'h08;
  localparam logic [7:0] C_MEMWRITE = 8'h04;
  localparam logic [7:0] C_REGWR    = 8'h02;
  localparam logic [7:0] C_ALUSRC   = 8'h01;

  // Instruction fields
  logic [5:0]        op_f;
  logic [5:0]        fn_f;
  logic [AWIDTH-1:0] rs_f;
  logic [AWIDTH-1:0] rt_f;
  logic [AWIDTH-1:0] rd_f;
  logic [DWIDTH-1:0] sext_f;
  logic [DWIDTH-1:0] zext_f;

  assign op_f   = d_i_instr[31:26];
  assign fn_f   = d_i_instr[5:0];
  assign rs_f   = AWIDTH'(d_i_instr[25:21]);
  assign rt_f   = AWIDTH'(d_i_instr[20:16]);
  assign rd_f   = AWIDTH'(d_i_instr[15:11]);
  assign sext_f = {{(DWIDTH-16){d_i_instr[15]}}, d_i_instr[15:0]};
  assign zext_f = {{(DWIDTH-16){1'b0}}, d_i_instr[15:0]};

  // Combinational decode of the incoming instruction
  logic                  dec_legal;
  logic [5:0]            dec_funct;
  logic [AWIDTH-1:0]     dec_rs;
  logic [AWIDTH-1:0]     dec_rt;
  logic [AWIDTH-1:0]     dec_rd;
  logic [DWIDTH-1:0]     dec_imm;
  logic [7:0]            dec_ctrl;
  logic [JUMP_WIDTH-1:0] dec_jal;
  // Registers actually read by the incoming instruction (rt-as-destination excluded)
  logic [AWIDTH-1:0]     src_rs;
  logic [AWIDTH-1:0]     src_rt;

  always_comb begin
    dec_legal = 1'b1;
    dec_funct = '0;
    dec_rs    = '0;
    dec_rt    = '0;
    dec_rd    = '0;
    dec_imm   = '0;
    dec_ctrl  = '0;
    dec_jal   = '0;
    src_rs    = '0;
    src_rt    = '0;
    case (op_f)
      OP_RTYPE: begin
        dec_funct = fn_f;
        dec_rs    = rs_f;
        src_rs    = rs_f;
        if (fn_f == FN_JR) begin
          dec_ctrl = C_JR;
        end else begin
          dec_rt   = rt_f;
          src_rt   = rt_f;
          dec_rd   = rd_f;
          dec_ctrl = C_REGWR;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        dec_rs   = rs_f;
        src_rs   = rs_f;
        dec_rt   = rt_f;
        dec_rd   = rt_f;
        dec_imm  = sext_f;
        dec_ctrl = C_ALUSRC | C_REGWR;
      end
      OP_ANDI, OP_ORI: begin
        dec_rs   = rs_f;
        src_rs   = rs_f;
        dec_rt   = rt_f;
        dec_rd   = rt_f;
        dec_imm  = zext_f;
        dec_ctrl = C_ALUSRC | C_REGWR;
      end
      OP_LUI: begin
        dec_rt   = rt_f;
        dec_rd   = rt_f;
        dec_imm  = zext_f << 16;
        dec_ctrl = C_ALUSRC | C_REGWR;
      end
      OP_LW: begin
        dec_rs   = rs_f;
        src_rs   = rs_f;
        dec_rt   = rt_f;
        dec_rd   = rt_f;
        dec_imm  = sext_f;
        dec_ctrl = C_ALUSRC | C_REGWR | C_MEMTOREG;
      end
      OP_SW: begin
        dec_rs   = rs_f;
        src_rs   = rs_f;
        dec_rt   = rt_f;
        src_rt   = rt_f;
        dec_imm  = sext_f;
        dec_ctrl = C_ALUSRC | C_MEMWRITE;
      end
      OP_BEQ, OP_BNE: begin
        dec_rs   = rs_f;
        src_rs   = rs_f;
        dec_rt   = rt_f;
        src_rt   = rt_f;
        dec_imm  = sext_f;
        dec_ctrl = C_BRANCH;
      end
      OP_J: begin
        dec_jal  = d_i_instr[JUMP_WIDTH-1:0];
        dec_ctrl = C_J;
      end
      OP_JAL: begin
        dec_jal  = d_i_instr[JUMP_WIDTH-1:0];
        dec_rd   = AWIDTH'(31);
        dec_ctrl = C_JAL | C_REGWR;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // ID/EX register state
  logic                  valid_q,   valid_d;
  logic [5:0]            opcode_q,  opcode_d;
  logic [5:0]            funct_q,   funct_d;
  logic [AWIDTH-1:0]     rs_q,      rs_d;
  logic [AWIDTH-1:0]     rt_q,      rt_d;
  logic [AWIDTH-1:0]     rd_q,      rd_d;
  logic [DWIDTH-1:0]     imm_q,     imm_d;
  logic [7:0]            ctrl_q,    ctrl_d;
  logic [JUMP_WIDTH-1:0] jal_q,     jal_d;
  logic [DWIDTH-1:0]     pc_q,      pc_d;
  logic                  illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;

  // A load in the register whose destination the incoming instruction reads
  logic hazard;
  logic accept;

  assign hazard = (HAZARD_EN != 0) && valid_q && ctrl_q[3] && (rd_q != '0) &&
                  ((rd_q == src_rs) || (rd_q == src_rt));

  // A flush always consumes the input so IF can redirect immediately
  assign d_o_ready = !d_rst && (d_i_flush || (!hazard && (!valid_q || d_i_ex_ready)));
  assign accept    = d_i_valid && d_o_ready;

  always_comb begin
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    funct_d   = funct_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    ctrl_d    = ctrl_q;
    jal_d     = jal_q;
    pc_d      = pc_q;
    illegal_d = 1'b0;
    cnt_d     = cnt_q;

    // Empty slot: flush, consumed with nothing new (covers the load-use bubble),
    // or an illegal instruction swallowed. All fields zeroed so ctrl cannot leak.
    if (d_i_flush || (accept && !dec_legal) || (!accept && d_i_ex_ready)) begin
      valid_d  = 1'b0;
      opcode_d = '0;
      funct_d  = '0;
      rs_d     = '0;
      rt_d     = '0;
      rd_d     = '0;
      imm_d    = '0;
      ctrl_d   = '0;
      jal_d    = '0;
      pc_d     = '0;
    end else if (accept) begin
      valid_d  = 1'b1;
      opcode_d = op_f;
      funct_d  = dec_funct;
      rs_d     = dec_rs;
      rt_d     = dec_rt;
      rd_d     = dec_rd;
      imm_d    = dec_imm;
      ctrl_d   = dec_ctrl;
      jal_d    = dec_jal;
      pc_d     = d_i_pc;
    end

    if (accept && !dec_legal && !d_i_flush) begin
      illegal_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge d_clk) begin
    if (d_rst) begin
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      funct_q   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
      jal_q     <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
      jal_q     <= jal_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign d_o_valid       = valid_q;
  assign d_o_opcode      = opcode_q;
  assign d_o_funct       = funct_q;
  assign d_o_addr_rs     = rs_q;
  assign d_o_addr_rt     = rt_q;
  assign d_o_addr_rd     = rd_q;
  assign d_o_imm         = imm_q;
  assign d_o_ctrl        = ctrl_q;
  assign d_o_jal_addr    = jal_q;
  assign d_o_pc          = pc_q;
  assign d_o_illegal     = illegal_q;
  assign d_o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - self-checking bench for decode_stage_pipe
//
// Purpose:
//   Unit 0 runs with the load-use stall enabled and an 8-bit counter, unit 1
//   with the stall disabled and a 2-bit counter. Each unit has its own inputs
//   and scoreboard queue of expected ID/EX contents.

module tb_decode_stage_pipe;

  typedef struct packed {
    logic        legal;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic [25:0] jal;
    logic [31:0] pc;
  } exp_t;

  localparam logic [31:0] I_ADDI = 32'h2009FFFF;
  localparam logic [31:0] I_ORI  = 32'h3409FFFF;
  localparam logic [31:0] I_LUI  = 32'h3C091234;
  localparam logic [31:0] I_LW   = 32'h8C080000;
  localparam logic [31:0] I_ADD  = 32'h01095020;
  localparam logic [31:0] I_SW   = 32'hAD090004;
  localparam logic [31:0] I_BEQ  = 32'h11090003;
  localparam logic [31:0] I_JR   = 32'h01000008;
  localparam logic [31:0] I_J    = 32'h08000040;
  localparam logic [31:0] I_ANDI = 32'h31290F0F;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_BAD  = 32'hFC000000;

  logic clk;
  logic        rst     [2];
  logic        i_valid [2];
  logic        flush   [2];
  logic        ex      [2];
  logic [31:0] i_instr [2];
  logic [31:0] i_pc    [2];
  logic        o_ready [2];
  logic        o_valid [2];
  logic [5:0]  o_op    [2];
  logic [5:0]  o_fn    [2];
  logic [4:0]  o_rs    [2];
  logic [4:0]  o_rt    [2];
  logic [4:0]  o_rd    [2];
  logic [31:0] o_imm   [2];
  logic [7:0]  o_ctrl  [2];
  logic [25:0] o_jal   [2];
  logic [31:0] o_pc    [2];
  logic        o_ill   [2];
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;

  int   checks;
  int   errors;
  exp_t sb [2][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  decode_stage_pipe #(.HAZARD_EN(1), .CNT_WIDTH(8)) dut_a (
    .d_clk(clk), .d_rst(rst[0]), .d_i_valid(i_valid[0]), .d_o_ready(o_ready[0]),
    .d_i_instr(i_instr[0]), .d_i_pc(i_pc[0]), .d_i_flush(flush[0]), .d_i_ex_ready(ex[0]),
    .d_o_valid(o_valid[0]), .d_o_opcode(o_op[0]), .d_o_funct(o_fn[0]),
    .d_o_addr_rs(o_rs[0]), .d_o_addr_rt(o_rt[0]), .d_o_addr_rd(o_rd[0]),
    .d_o_imm(o_imm[0]), .d_o_ctrl(o_ctrl[0]), .d_o_jal_addr(o_jal[0]), .d_o_pc(o_pc[0]),
    .d_o_illegal(o_ill[0]), .d_o_illegal_cnt(cnt_a)
  );

  decode_stage_pipe #(.HAZARD_EN(0), .CNT_WIDTH(2)) dut_b (
    .d_clk(clk), .d_rst(rst[1]), .d_i_valid(i_valid[1]), .d_o_ready(o_ready[1]),
    .d_i_instr(i_instr[1]), .d_i_pc(i_pc[1]), .d_i_flush(flush[1]), .d_i_ex_ready(ex[1]),
    .d_o_valid(o_valid[1]), .d_o_opcode(o_op[1]), .d_o_funct(o_fn[1]),
    .d_o_addr_rs(o_rs[1]), .d_o_addr_rt(o_rt[1]), .d_o_addr_rd(o_rd[1]),
    .d_o_imm(o_imm[1]), .d_o_ctrl(o_ctrl[1]), .d_o_jal_addr(o_jal[1]), .d_o_pc(o_pc[1]),
    .d_o_illegal(o_ill[1]), .d_o_illegal_cnt(cnt_b)
  );

  // Reference decode of one instruction into the expected ID/EX contents
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    e       = '0;
    e.legal = 1'b1;
    e.op    = ins[31:26];
    e.pc    = pc;
    case (ins[31:26])
      6'h00: begin
        e.funct = ins[5:0];
        e.rs    = ins[25:21];
        if (ins[5:0] == 6'h08) e.ctrl = 8'h40;
        else begin
          e.rt = ins[20:16]; e.rd = ins[15:11]; e.ctrl = 8'h02;
        end
      end
      6'h08, 6'h09, 6'h0A, 6'h0B: begin
        e.rs = ins[25:21]; e.rt = ins[20:16]; e.rd = ins[20:16];
        e.imm = {{16{ins[15]}}, ins[15:0]}; e.ctrl = 8'h03;
      end
      6'h0C, 6'h0D: begin
        e.rs = ins[25:21]; e.rt = ins[20:16]; e.rd = ins[20:16];
        e.imm = {16'h0000, ins[15:0]}; e.ctrl = 8'h03;
      end
      6'h0F: begin
        e.rt = ins[20:16]; e.rd = ins[20:16];
        e.imm = {ins[15:0], 16'h0000}; e.ctrl = 8'h03;
      end
      6'h23: begin
        e.rs = ins[25:21]; e.rt = ins[20:16]; e.rd = ins[20:16];
        e.imm = {{16{ins[15]}}, ins[15:0]}; e.ctrl = 8'h0B;
      end
      6'h2B: begin
        e.rs = ins[25:21]; e.rt = ins[20:16];
        e.imm = {{16{ins[15]}}, ins[15:0]}; e.ctrl = 8'h05;
      end
      6'h04, 6'h05: begin
        e.rs = ins[25:21]; e.rt = ins[20:16];
        e.imm = {{16{ins[15]}}, ins[15:0]}; e.ctrl = 8'h10;
      end
      6'h02: begin e.jal = ins[25:0]; e.ctrl = 8'h80; end
      6'h03: begin e.jal = ins[25:0]; e.rd = 5'd31; e.ctrl = 8'h22; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic exp_t act(input int u);
    exp_t a;
    a.legal = o_valid[u];
    a.op    = o_op[u];
    a.funct = o_fn[u];
    a.rs    = o_rs[u];
    a.rt    = o_rt[u];
    a.rd    = o_rd[u];
    a.imm   = o_imm[u];
    a.ctrl  = o_ctrl[u];
    a.jal   = o_jal[u];
    a.pc    = o_pc[u];
    return a;
  endfunction

  // Scoreboard: push on acceptance, pop and compare when EX consumes
  task automatic monitor();
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (rst[u]) begin
          sb[u].delete();
        end else begin
          if (flush[u]) begin
            if (o_valid[u] && sb[u].size() > 0) void'(sb[u].pop_front());
          end else begin
            if (o_valid[u] && ex[u]) begin
              checks++;
              if (sb[u].size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected unit %0d: issued op %h pc %h, required no issue",
                         u, o_op[u], o_pc[u]);
              end else begin
                e = sb[u].pop_front();
                a = act(u);
                if (a !== e) begin
                  errors++;
                  $display("FAIL sb_fields unit %0d: got %h required %h", u, a, e);
                end
              end
            end
            if (i_valid[u] && o_ready[u]) begin
              e = model(i_instr[u], i_pc[u]);
              if (e.legal) sb[u].push_back(e);
            end
          end
          if (!o_valid[u]) begin
            checks++;
            if (o_ctrl[u] !== 8'h00) begin
              errors++;
              $display("FAIL bubble_ctrl unit %0d: got %h required 00", u, o_ctrl[u]);
            end
          end
        end
      end
    end
  endtask

  // Present one instruction and return at posedge+1 after it was taken
  task automatic send(input int u, input logic [31:0] ins, input logic [31:0] pc);
    bit ok;
    ok = 0;
    i_valid[u] = 1'b1;
    i_instr[u] = ins;
    i_pc[u]    = pc;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(negedge clk);
      ok = o_ready[u];
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout unit %0d: instr %h not accepted in 10 cycles", u, ins);
    end
  endtask

  task automatic drain(input int u);
    i_valid[u] = 1'b0;
    ex[u]      = 1'b1;
    for (int n = 0; n < 20 && sb[u].size() != 0; n++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb[u].size() != 0) begin
      errors++;
      $display("FAIL drain unit %0d: %0d entries left, required 0", u, sb[u].size());
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (act(u) !== exp_t'(0) || o_ready[u] !== 1'b0 || o_ill[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state unit %0d: got %h ready %b ill %b, required all 0",
                 u, act(u), o_ready[u], o_ill[u]);
      end
    end
    checks++;
    if (cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d required 0/0", cnt_a, cnt_b);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    fork monitor(); join_none
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (o_ready[u] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release_ready unit %0d: got %b required 1", u, o_ready[u]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_decode(input int u);
    logic [31:0] prog [9];
    prog = '{I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_JR, I_ADD, I_J, I_ANDI};
    ex[u] = 1'b1;
    send(u, I_ADDI, 32'h1000);
    i_valid[u] = 1'b0;
    @(negedge clk);
    checks++;
    if (o_valid[u] !== 1'b1 || o_imm[u] !== 32'hFFFFFFFF || o_rd[u] !== 5'd9 || o_ctrl[u] !== 8'h03) begin
      errors++;
      $display("FAIL addi_latency unit %0d: valid %b imm %h rd %0d ctrl %h, required 1 ffffffff 9 03",
               u, o_valid[u], o_imm[u], o_rd[u], o_ctrl[u]);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) send(u, prog[i], 32'h1004 + 32'(i) * 4);
    drain(u);
  endtask

  task automatic test_hazard(input int u);
    int stalls;
    int add_at;
    bit acc;
    stalls = 0;
    add_at = 0;
    acc    = 0;
    ex[u]      = 1'b1;
    i_valid[u] = 1'b1;
    i_instr[u] = I_LW;
    i_pc[u]    = 32'h200;
    @(negedge clk);
    checks++;
    if (o_ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL hazard_lw_accept unit %0d: ready %b required 1", u, o_ready[u]);
    end
    @(posedge clk); #1;
    i_instr[u] = I_ADD;
    i_pc[u]    = 32'h204;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (add_at == 0 && o_valid[u] && o_op[u] == 6'h00) add_at = k;
      if (!acc) begin
        if (o_ready[u]) acc = 1;
        else stalls++;
      end
      @(posedge clk); #1;
      if (acc) i_valid[u] = 1'b0;
    end
    checks++;
    if (stalls != (u == 0 ? 1 : 0)) begin
      errors++;
      $display("FAIL hazard_stalls unit %0d: got %0d required %0d", u, stalls, (u == 0 ? 1 : 0));
    end
    checks++;
    if (add_at != (u == 0 ? 3 : 2)) begin
      errors++;
      $display("FAIL hazard_add_slot unit %0d: got %0d required %0d", u, add_at, (u == 0 ? 3 : 2));
    end
    drain(u);
  endtask

  task automatic test_stall(input int u);
    exp_t e;
    e = model(I_ORI, 32'h400);
    ex[u] = 1'b1;
    send(u, I_ORI, 32'h400);
    ex[u]      = 1'b0;
    i_instr[u] = I_ANDI;
    i_pc[u]    = 32'h404;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (act(u) !== e || o_ready[u] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold unit %0d cycle %0d: got %h ready %b, required %h ready 0",
                 u, k, act(u), o_ready[u], e);
      end
      @(posedge clk); #1;
    end
    ex[u] = 1'b1;
    @(negedge clk);
    checks++;
    if (o_ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready unit %0d: got %b required 1", u, o_ready[u]);
    end
    @(posedge clk); #1;
    i_valid[u] = 1'b0;
    @(negedge clk);
    checks++;
    if (o_valid[u] !== 1'b1 || o_op[u] !== 6'h0C) begin
      errors++;
      $display("FAIL stall_next_instr unit %0d: valid %b op %h required 1 0c", u, o_valid[u], o_op[u]);
    end
    @(posedge clk); #1;
    drain(u);
  endtask

  task automatic test_flush(input int u);
    ex[u] = 1'b1;
    send(u, I_ADDI, 32'h300);
    ex[u]      = 1'b0;
    i_instr[u] = I_BEQ;
    i_pc[u]    = 32'h304;
    flush[u]   = 1'b1;
    @(negedge clk);
    checks++;
    if (o_ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready unit %0d: got %b required 1", u, o_ready[u]);
    end
    @(posedge clk); #1;
    flush[u]   = 1'b0;
    i_valid[u] = 1'b0;
    ex[u]      = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (o_valid[u] !== 1'b0) begin
        errors++;
        $display("FAIL flush_killed unit %0d cycle %0d: valid %b required 0", u, k, o_valid[u]);
      end
      @(posedge clk); #1;
    end
    i_valid[u] = 1'b1;
    i_instr[u] = I_BAD;
    flush[u]   = 1'b1;
    @(posedge clk); #1;
    flush[u]   = 1'b0;
    i_valid[u] = 1'b0;
    @(negedge clk);
    checks++;
    if (o_ill[u] !== 1'b0 || cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL flush_suppress_illegal unit %0d: ill %b cnt %0d required 0 0", u, o_ill[u], cnt_a);
    end
    @(posedge clk); #1;
    drain(u);
  endtask

  task automatic test_illegal(input int u);
    int pulses;
    pulses = 0;
    ex[u]  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      i_valid[u] = 1'b1;
      i_instr[u] = I_BAD;
      i_pc[u]    = 32'h500;
      @(negedge clk);
      checks++;
      if (o_ready[u] !== 1'b1 || o_ill[u] !== 1'b0) begin
        errors++;
        $display("FAIL illegal_pre unit %0d n %0d: ready %b ill %b required 1 0", u, i, o_ready[u], o_ill[u]);
      end
      @(posedge clk); #1;
      i_valid[u] = 1'b0;
      @(negedge clk);
      if (o_ill[u] === 1'b1) pulses++;
      checks++;
      if (o_ill[u] !== 1'b1 || o_valid[u] !== 1'b0 || cnt_b !== 2'(i > 3 ? 3 : i)) begin
        errors++;
        $display("FAIL illegal_pulse unit %0d n %0d: ill %b valid %b cnt %0d required 1 0 %0d",
                 u, i, o_ill[u], o_valid[u], cnt_b, (i > 3 ? 3 : i));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 5) begin
      errors++;
      $display("FAIL illegal_pulse_count unit %0d: got %0d required 5", u, pulses);
    end
    send(u, I_JAL, 32'h600);
    drain(u);
  endtask

  task automatic test_reset_mid(input int u);
    ex[u] = 1'b1;
    send(u, I_ADDI, 32'h700);
    i_instr[u] = I_ORI;
    rst[u]     = 1'b1;
    @(negedge clk);
    checks++;
    if (o_ready[u] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready unit %0d: got %b required 0", u, o_ready[u]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (act(u) !== exp_t'(0) || o_ready[u] !== 1'b0 || cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL midreset_state unit %0d: got %h ready %b cnt %0d required all 0",
               u, act(u), o_ready[u], cnt_a);
    end
    @(posedge clk); #1;
    rst[u]     = 1'b0;
    i_valid[u] = 1'b0;
    @(negedge clk);
    checks++;
    if (o_ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_release unit %0d: got %b required 1", u, o_ready[u]);
    end
    @(posedge clk); #1;
    drain(u);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int u = 0; u < 2; u++) begin
      rst[u]     = 1'b1;
      i_valid[u] = 1'b0;
      flush[u]   = 1'b0;
      ex[u]      = 1'b1;
      i_instr[u] = '0;
      i_pc[u]    = '0;
    end
    test_reset();
    test_decode(0);
    test_hazard(0);
    test_hazard(1);
    test_stall(0);
    test_flush(0);
    test_illegal(1);
    test_reset_mid(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
